// File: rtl/register_rename_file.sv
// Architectural register file plus rename table: answers operand/rename queries one
// cycle after an accepted request and tracks which ROB tag will produce each register.
module register_rename_file #(
  parameter int REGNUM = 32,
  parameter int ROBIDW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              rename_need,
  input  logic              rename_need_ins_is_simple,
  input  logic              rename_need_ins_is_branch_or_store,
  input  logic [ROBIDW-1:0] rename_need_id,
  input  logic              operand_1_flag,
  input  logic [4:0]        operand_1_reg,
  input  logic              operand_2_flag,
  input  logic [4:0]        operand_2_reg,
  input  logic [ROBIDW-1:0] new_ins_rd_rename,
  input  logic [4:0]        new_ins_rd,
  input  logic              commit_flag,
  input  logic [4:0]        commit_reg,
  input  logic [ROBIDW-1:0] commit_rename,
  input  logic [31:0]       commit_value,
  input  logic              reg_flush,
  output logic              rename_finish,
  output logic [ROBIDW-1:0] rename_finish_id,
  output logic              operand_1_busy,
  output logic [ROBIDW-1:0] operand_1_rename,
  output logic [31:0]       operand_1_data_from_reg,
  output logic              operand_2_busy,
  output logic [ROBIDW-1:0] operand_2_rename,
  output logic [31:0]       operand_2_data_from_reg
);

  logic [31:0]       value_reg [REGNUM];
  logic              busy_reg  [REGNUM];
  logic [ROBIDW-1:0] tag_reg   [REGNUM];
  logic [31:0]       value_next [REGNUM];
  logic              busy_next  [REGNUM];
  logic [ROBIDW-1:0] tag_next   [REGNUM];

  logic accept;
  logic resp_en;
  logic rd_rename_en;
  logic commit_en;

  assign accept       = rdy && rename_need && !reg_flush;
  assign resp_en      = accept && !rename_need_ins_is_simple;
  assign rd_rename_en = accept && !rename_need_ins_is_branch_or_store && (new_ins_rd != 5'd0);
  assign commit_en    = rdy && commit_flag && (commit_reg != 5'd0);

  // Per-register next state; a same-cycle rename of the register beats the commit's busy clear.
  genvar gi;
  generate
    for (gi = 0; gi < REGNUM; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign value_next[gi] = '0;
        assign busy_next[gi]  = 1'b0;
        assign tag_next[gi]   = '0;
      end else begin : g_arch
        logic rn_hit;
        logic cm_hit;
        assign rn_hit         = rd_rename_en && (new_ins_rd == 5'(gi));
        assign cm_hit         = commit_en && (commit_reg == 5'(gi));
        assign value_next[gi] = cm_hit ? commit_value : value_reg[gi];
        assign tag_next[gi]   = rn_hit ? new_ins_rd_rename : tag_reg[gi];
        assign busy_next[gi]  = reg_flush ? 1'b0 :
                                rn_hit    ? 1'b1 :
                                (cm_hit && (tag_reg[gi] == commit_rename)) ? 1'b0 :
                                busy_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGNUM; i++) begin
        value_reg[i] <= '0;
        busy_reg[i]  <= 1'b0;
        tag_reg[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < REGNUM; i++) begin
        value_reg[i] <= value_next[i];
        busy_reg[i]  <= busy_next[i];
        tag_reg[i]   <= tag_next[i];
      end
    end
  end

  // Operand lookup sees the table before this request's own rd rename.
  logic              op_busy_next   [2];
  logic [ROBIDW-1:0] op_rename_next [2];
  logic [31:0]       op_data_next   [2];
  logic              op_busy_reg    [2];
  logic [ROBIDW-1:0] op_rename_reg  [2];
  logic [31:0]       op_data_reg    [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      logic       flag;
      logic [4:0] sel;
      logic       hit_busy;
      logic       bypass;
      assign flag     = (gi == 0) ? operand_1_flag : operand_2_flag;
      assign sel      = (gi == 0) ? operand_1_reg : operand_2_reg;
      assign hit_busy = flag && (sel != 5'd0) && busy_reg[sel];
      assign bypass   = hit_busy && commit_flag && (commit_reg == sel) &&
                        (commit_rename == tag_reg[sel]);
      assign op_busy_next[gi]   = hit_busy && !bypass;
      assign op_rename_next[gi] = (hit_busy && !bypass) ? tag_reg[sel] : '0;
      assign op_data_next[gi]   = (!flag || (sel == 5'd0)) ? 32'd0 :
                                  bypass   ? commit_value :
                                  hit_busy ? 32'd0 : value_reg[sel];
    end
  endgenerate

  logic              finish_reg;
  logic [ROBIDW-1:0] finish_id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish_reg    <= 1'b0;
      finish_id_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        op_busy_reg[i]   <= 1'b0;
        op_rename_reg[i] <= '0;
        op_data_reg[i]   <= '0;
      end
    end else if (rdy) begin
      if (resp_en) begin
        finish_reg    <= 1'b1;
        finish_id_reg <= rename_need_id;
        for (int i = 0; i < 2; i++) begin
          op_busy_reg[i]   <= op_busy_next[i];
          op_rename_reg[i] <= op_rename_next[i];
          op_data_reg[i]   <= op_data_next[i];
        end
      end else begin
        finish_reg <= 1'b0;
      end
    end
  end

  assign rename_finish           = finish_reg;
  assign rename_finish_id        = finish_id_reg;
  assign operand_1_busy          = op_busy_reg[0];
  assign operand_1_rename        = op_rename_reg[0];
  assign operand_1_data_from_reg = op_data_reg[0];
  assign operand_2_busy          = op_busy_reg[1];
  assign operand_2_rename        = op_rename_reg[1];
  assign operand_2_data_from_reg = op_data_reg[1];

endmodule

// File: tb/tb_register_rename_file.sv
// Table-driven bench for register_rename_file: each vector's expected response is queued
// when driven and compared one cycle later, plus hand sequences for rdy hold and async reset.
module tb_register_rename_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        rename_need = 1'b0;
  logic        rename_need_ins_is_simple = 1'b0;
  logic        rename_need_ins_is_branch_or_store = 1'b0;
  logic [3:0]  rename_need_id = '0;
  logic        operand_1_flag = 1'b0;
  logic [4:0]  operand_1_reg = '0;
  logic        operand_2_flag = 1'b0;
  logic [4:0]  operand_2_reg = '0;
  logic [3:0]  new_ins_rd_rename = '0;
  logic [4:0]  new_ins_rd = '0;
  logic        commit_flag = 1'b0;
  logic [4:0]  commit_reg = '0;
  logic [3:0]  commit_rename = '0;
  logic [31:0] commit_value = '0;
  logic        reg_flush = 1'b0;
  logic        rename_finish;
  logic [3:0]  rename_finish_id;
  logic        operand_1_busy;
  logic [3:0]  operand_1_rename;
  logic [31:0] operand_1_data_from_reg;
  logic        operand_2_busy;
  logic [3:0]  operand_2_rename;
  logic [31:0] operand_2_data_from_reg;

  register_rename_file #(.REGNUM(32), .ROBIDW(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rename_need(rename_need),
    .rename_need_ins_is_simple(rename_need_ins_is_simple),
    .rename_need_ins_is_branch_or_store(rename_need_ins_is_branch_or_store),
    .rename_need_id(rename_need_id),
    .operand_1_flag(operand_1_flag), .operand_1_reg(operand_1_reg),
    .operand_2_flag(operand_2_flag), .operand_2_reg(operand_2_reg),
    .new_ins_rd_rename(new_ins_rd_rename), .new_ins_rd(new_ins_rd),
    .commit_flag(commit_flag), .commit_reg(commit_reg),
    .commit_rename(commit_rename), .commit_value(commit_value),
    .reg_flush(reg_flush),
    .rename_finish(rename_finish), .rename_finish_id(rename_finish_id),
    .operand_1_busy(operand_1_busy), .operand_1_rename(operand_1_rename),
    .operand_1_data_from_reg(operand_1_data_from_reg),
    .operand_2_busy(operand_2_busy), .operand_2_rename(operand_2_rename),
    .operand_2_data_from_reg(operand_2_data_from_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int need, simple, bs, id, f1, r1, f2, r2, rd, rdtag, cf, creg, ctag, cval, flush;
    int e_fin, e_id, e_b1, e_n1, e_d1, e_b2, e_n2, e_d2;
  } vec_t;

  vec_t tbl[26];
  vec_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rename_need                        = v.need[0];
    rename_need_ins_is_simple          = v.simple[0];
    rename_need_ins_is_branch_or_store = v.bs[0];
    rename_need_id                     = 4'(v.id);
    operand_1_flag                     = v.f1[0];
    operand_1_reg                      = 5'(v.r1);
    operand_2_flag                     = v.f2[0];
    operand_2_reg                      = 5'(v.r2);
    new_ins_rd                         = 5'(v.rd);
    new_ins_rd_rename                  = 4'(v.rdtag);
    commit_flag                        = v.cf[0];
    commit_reg                         = 5'(v.creg);
    commit_rename                      = 4'(v.ctag);
    commit_value                       = 32'(v.cval);
    reg_flush                          = v.flush[0];
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    apply(v);
    sb_q.push_back(v);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      $display("vec %0d: fin=%0d id=%0d b1=%0d n1=%0d d1=%0h b2=%0d n2=%0d d2=%0h", idx,
               rename_finish, rename_finish_id, operand_1_busy, operand_1_rename,
               operand_1_data_from_reg, operand_2_busy, operand_2_rename, operand_2_data_from_reg);
      chk($sformatf("v%0d_finish", idx), int'(rename_finish), e.e_fin);
      if (e.e_fin != 0) begin
        chk($sformatf("v%0d_id", idx), int'(rename_finish_id), e.e_id);
        chk($sformatf("v%0d_busy1", idx), int'(operand_1_busy), e.e_b1);
        chk($sformatf("v%0d_rename1", idx), int'(operand_1_rename), e.e_n1);
        chk($sformatf("v%0d_data1", idx), int'(operand_1_data_from_reg), e.e_d1);
        chk($sformatf("v%0d_busy2", idx), int'(operand_2_busy), e.e_b2);
        chk($sformatf("v%0d_rename2", idx), int'(operand_2_rename), e.e_n2);
        chk($sformatf("v%0d_data2", idx), int'(operand_2_data_from_reg), e.e_d2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    vec_t q;
    z = '{default: 0};
    //            need sim bs id f1 r1 f2 r2 rd rdt cf cr ct cval    fl | fin id b1 n1 d1      b2 n2 d2
    tbl[0]  = '{1, 0, 1, 7,  1, 3, 1, 4, 0, 0,  0, 0, 0, 0,      0,  1, 7,  0, 0,  0,      0, 0,  0};
    tbl[1]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0,      0,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[2]  = '{1, 0, 0, 1,  0, 0, 0, 0, 5, 2,  0, 0, 0, 0,      0,  1, 1,  0, 0,  0,      0, 0,  0};
    tbl[3]  = '{1, 0, 1, 2,  1, 5, 0, 0, 0, 0,  0, 0, 0, 0,      0,  1, 2,  1, 2,  0,      0, 0,  0};
    tbl[4]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 5, 2, 'h1234, 0,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[5]  = '{1, 0, 1, 3,  1, 5, 0, 0, 0, 0,  0, 0, 0, 0,      0,  1, 3,  0, 0,  'h1234, 0, 0,  0};
    tbl[6]  = '{1, 0, 0, 4,  0, 0, 0, 0, 5, 2,  0, 0, 0, 0,      0,  1, 4,  0, 0,  0,      0, 0,  0};
    tbl[7]  = '{1, 0, 1, 5,  1, 5, 0, 0, 0, 0,  1, 5, 2, 'hBEEF, 0,  1, 5,  0, 0,  'hBEEF, 0, 0,  0};
    tbl[8]  = '{1, 0, 0, 6,  0, 0, 0, 0, 6, 3,  0, 0, 0, 0,      0,  1, 6,  0, 0,  0,      0, 0,  0};
    tbl[9]  = '{1, 0, 0, 8,  1, 6, 0, 0, 6, 9,  0, 0, 0, 0,      0,  1, 8,  1, 3,  0,      0, 0,  0};
    tbl[10] = '{1, 0, 1, 9,  0, 0, 1, 6, 0, 0,  1, 6, 3, 'h66,   0,  1, 9,  0, 0,  0,      1, 9,  0};
    tbl[11] = '{1, 0, 1, 10, 1, 6, 0, 0, 0, 0,  0, 0, 0, 0,      0,  1, 10, 1, 9,  0,      0, 0,  0};
    tbl[12] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 7, 1, 'h77,   0,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[13] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  1, 8, 1, 'h88,   0,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[14] = '{1, 0, 0, 11, 0, 0, 0, 0, 7, 10, 0, 0, 0, 0,      0,  1, 11, 0, 0,  0,      0, 0,  0};
    tbl[15] = '{1, 0, 0, 12, 0, 0, 0, 0, 8, 11, 0, 0, 0, 0,      0,  1, 12, 0, 0,  0,      0, 0,  0};
    tbl[16] = '{1, 0, 1, 13, 1, 7, 1, 8, 0, 0,  0, 0, 0, 0,      0,  1, 13, 1, 10, 0,      1, 11, 0};
    tbl[17] = '{1, 0, 0, 14, 1, 7, 0, 0, 9, 12, 1, 8, 11, 'h888, 1,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[18] = '{1, 0, 1, 15, 1, 7, 1, 8, 0, 0,  0, 0, 0, 0,      0,  1, 15, 0, 0,  'h77,   0, 0,  'h888};
    tbl[19] = '{1, 0, 1, 0,  1, 9, 1, 6, 0, 0,  0, 0, 0, 0,      0,  1, 0,  0, 0,  0,      0, 0,  'h66};
    tbl[20] = '{1, 1, 0, 1,  0, 0, 0, 0, 1, 4,  0, 0, 0, 0,      0,  0, 0,  0, 0,  0,      0, 0,  0};
    tbl[21] = '{1, 0, 1, 2,  1, 1, 1, 0, 0, 0,  0, 0, 0, 0,      0,  1, 2,  1, 4,  0,      0, 0,  0};
    tbl[22] = '{1, 0, 0, 3,  1, 0, 0, 0, 0, 5,  1, 0, 0, 'hDEAD, 0,  1, 3,  0, 0,  0,      0, 0,  0};
    tbl[23] = '{1, 0, 1, 4,  1, 0, 1, 0, 0, 0,  0, 0, 0, 0,      0,  1, 4,  0, 0,  0,      0, 0,  0};
    tbl[24] = '{1, 0, 0, 5,  0, 0, 0, 0, 10, 6, 1, 1, 4, 'h11,   0,  1, 5,  0, 0,  0,      0, 0,  0};
    tbl[25] = '{1, 0, 1, 6,  1, 10, 1, 1, 0, 0, 0, 0, 0, 0,      0,  1, 6,  1, 6,  0,      0, 0,  'h11};

    // Reset state while rst_n is held low.
    apply(z);
    repeat (2) @(negedge clk);
    $display("reset: fin=%0d id=%0d d1=%0h", rename_finish, rename_finish_id, operand_1_data_from_reg);
    chk("reset_finish", int'(rename_finish), 0);
    chk("reset_id", int'(rename_finish_id), 0);
    chk("reset_busy1", int'(operand_1_busy), 0);
    chk("reset_data1", int'(operand_1_data_from_reg), 0);
    chk("reset_data2", int'(operand_2_data_from_reg), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) step(tbl[i], i);

    // rdy low holds an asserted response and blocks request and commit.
    q = z; q.need = 1; q.bs = 1; q.id = 6; q.f1 = 1; q.r1 = 5;
    apply(q);
    @(negedge clk);
    $display("rdy seq A: fin=%0d id=%0d d1=%0h", rename_finish, rename_finish_id, operand_1_data_from_reg);
    chk("rdy_pre_finish", int'(rename_finish), 1);
    chk("rdy_pre_data1", int'(operand_1_data_from_reg), 'hBEEF);
    rdy = 1'b0;
    q.id = 9; q.r1 = 6; q.cf = 1; q.creg = 5; q.cval = 'h5555;
    apply(q);
    repeat (2) @(negedge clk);
    $display("rdy seq B: fin=%0d id=%0d d1=%0h", rename_finish, rename_finish_id, operand_1_data_from_reg);
    chk("rdy_hold_finish", int'(rename_finish), 1);
    chk("rdy_hold_id", int'(rename_finish_id), 6);
    chk("rdy_hold_data1", int'(operand_1_data_from_reg), 'hBEEF);
    rdy = 1'b1;
    apply(z);
    @(negedge clk);
    $display("rdy seq C: fin=%0d", rename_finish);
    chk("rdy_release_finish", int'(rename_finish), 0);
    q = z; q.need = 1; q.bs = 1; q.id = 2; q.f1 = 1; q.r1 = 5;
    apply(q);
    @(negedge clk);
    $display("rdy seq D: fin=%0d d1=%0h", rename_finish, operand_1_data_from_reg);
    chk("rdy_commit_blocked", int'(operand_1_data_from_reg), 'hBEEF);

    // Asynchronous reset in the middle of a response.
    q.id = 3;
    apply(q);
    @(negedge clk);
    chk("arst_pre_finish", int'(rename_finish), 1);
    apply(z);
    #2 rst_n = 1'b0;
    #1;
    $display("arst: fin=%0d id=%0d d1=%0h", rename_finish, rename_finish_id, operand_1_data_from_reg);
    chk("arst_finish", int'(rename_finish), 0);
    chk("arst_id", int'(rename_finish_id), 0);
    chk("arst_data1", int'(operand_1_data_from_reg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.id = 4;
    apply(q);
    @(negedge clk);
    $display("arst after: fin=%0d b1=%0d d1=%0h", rename_finish, operand_1_busy, operand_1_data_from_reg);
    chk("arst_after_finish", int'(rename_finish), 1);
    chk("arst_after_data1", int'(operand_1_data_from_reg), 0);
    apply(z);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
